// File: rtl/vx_raster_dcr_writer.sv
// rtl/vx_raster_dcr_writer.sv - serialises a packed raster state record into six DCR writes
// Optional build macro: RASTER_DCR_DELTA_EN (skip words whose value has not changed).
module vx_raster_dcr_writer #(
    parameter                           INSTANCE_ID   = "",
    parameter int                       DCR_ADDR_BITS = 12,
    parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE      = '0,
    parameter int                       GAP_CYCLES    = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_tbuf_addr_i,
    input  logic [15:0]              req_tile_count_i,
    input  logic [31:0]              req_pbuf_addr_i,
    input  logic [15:0]              req_pbuf_stride_i,
    input  logic [15:0]              req_xmin_i,
    input  logic [15:0]              req_xmax_i,
    input  logic [15:0]              req_ymin_i,
    input  logic [15:0]              req_ymax_i,
    output logic                     dcr_wr_valid_o,
    output logic [DCR_ADDR_BITS-1:0] dcr_wr_addr_o,
    output logic [31:0]              dcr_wr_data_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         NUM_WORDS = 6;
    // The gap counter is loaded with the last count value so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    // The trace tag has no hardware meaning; it is folded into a sink so it stays referenced.
    logic id_tag_unused;
    assign id_tag_unused = ^INSTANCE_ID;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  pend_q, pend_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] word_q [0:NUM_WORDS-1];
    logic [31:0] word_d [0:NUM_WORDS-1];
    logic [31:0] new_word [0:NUM_WORDS-1];
    logic [5:0]  send_mask;
    logic [5:0]  pend_left;
    logic        accept;

    // Lowest pending word index; words are always sent in ascending address order.
    function automatic logic [2:0] first_set(input logic [5:0] v);
        first_set = 3'd0;
        for (int i = NUM_WORDS - 1; i >= 0; i--) begin
            if (v[i]) begin
                first_set = 3'(i);
            end
        end
    endfunction

    // The record as it will appear on the bus, one 32-bit word per DCR.
    assign new_word[0] = req_tbuf_addr_i;
    assign new_word[1] = {16'h0000, req_tile_count_i};
    assign new_word[2] = req_pbuf_addr_i;
    assign new_word[3] = {16'h0000, req_pbuf_stride_i};
    assign new_word[4] = {req_xmax_i, req_xmin_i};
    assign new_word[5] = {req_ymax_i, req_ymin_i};

    assign req_ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept      = req_valid_i && req_ready_o;

`ifdef RASTER_DCR_DELTA_EN
    logic [31:0] copy_q [0:NUM_WORDS-1];
    logic [5:0]  dirty_q;

    // A word needs sending when its shadow is stale or its value has changed.
    always_comb begin
        send_mask = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            send_mask[i] = dirty_q[i] || (new_word[i] != copy_q[i]);
        end
    end

    // Shadow copies track what the raster units actually hold, updated as each word goes out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dirty_q <= 6'h3F;
            for (int i = 0; i < NUM_WORDS; i++) begin
                copy_q[i] <= '0;
            end
        end else if (state_q == S_WRITE) begin
            copy_q[idx_q]  <= word_q[idx_q];
            dirty_q[idx_q] <= 1'b0;
        end
    end
`else
    // Without shadow storage every word of every record is sent.
    assign send_mask = 6'h3F;
`endif

    assign pend_left = pend_q & ~(6'b000001 << idx_q);

    // Sequencer: accept a record, walk the pending words, optionally idle between writes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    word_d = new_word;
                    pend_d = send_mask;
                    idx_d  = first_set(send_mask);
                    if (send_mask == 6'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                pend_d = pend_left;
                if (pend_left == 6'h00) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = first_set(pend_left);
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LAST;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_WRITE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            gap_q   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
        end
    end

    // Bus outputs are driven only in WRITE so address and data read zero while idle.
    assign dcr_wr_valid_o = (state_q == S_WRITE);
    assign dcr_wr_addr_o  = dcr_wr_valid_o ? (DCR_BASE + DCR_ADDR_BITS'(idx_q)) : '0;
    assign dcr_wr_data_o  = dcr_wr_valid_o ? word_q[idx_q] : '0;
    assign busy_o         = (state_q == S_WRITE) || (state_q == S_GAP);
    assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_vx_raster_dcr_writer.sv
// tb/tb_vx_raster_dcr_writer.sv - scoreboard bench for vx_raster_dcr_writer
module tb_vx_raster_dcr_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1;
    logic [31:0] tbuf, pbuf;
    logic [15:0] tiles, stride, xmin, xmax, ymin, ymax;
    logic        r0, wv0, b0, d0, r1, wv1, b1, d1;
    logic [11:0] wa0, wa1;
    logic [31:0] wd0, wd1;

    vx_raster_dcr_writer #(.INSTANCE_ID("base0"), .DCR_ADDR_BITS(12), .DCR_BASE(12'h000), .GAP_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(v0), .req_ready_o(r0),
        .req_tbuf_addr_i(tbuf), .req_tile_count_i(tiles), .req_pbuf_addr_i(pbuf),
        .req_pbuf_stride_i(stride), .req_xmin_i(xmin), .req_xmax_i(xmax),
        .req_ymin_i(ymin), .req_ymax_i(ymax), .dcr_wr_valid_o(wv0), .dcr_wr_addr_o(wa0),
        .dcr_wr_data_o(wd0), .busy_o(b0), .done_o(d0));

    vx_raster_dcr_writer #(.INSTANCE_ID("gap2"), .DCR_ADDR_BITS(12), .DCR_BASE(12'hFFE), .GAP_CYCLES(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(v1), .req_ready_o(r1),
        .req_tbuf_addr_i(tbuf), .req_tile_count_i(tiles), .req_pbuf_addr_i(pbuf),
        .req_pbuf_stride_i(stride), .req_xmin_i(xmin), .req_xmax_i(xmax),
        .req_ymin_i(ymin), .req_ymax_i(ymax), .dcr_wr_valid_o(wv1), .dcr_wr_addr_o(wa1),
        .dcr_wr_data_o(wd1), .busy_o(b1), .done_o(d1));

    typedef struct {
        logic [31:0] tbuf;
        logic [15:0] tiles;
        logic [31:0] pbuf;
        logic [15:0] stride, xmin, xmax, ymin, ymax;
    } rec_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$], q1[$];
    int   dq0[$], dq1[$];
    exp_t e0, e1;
    int   de0, de1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    rec_t rec_a = '{32'h1000, 16'd8, 32'h2000, 16'd64, 16'd0, 16'd639, 16'd0, 16'd479};
    rec_t rec_b = '{32'h3000, 16'd3, 32'h4000, 16'd32, 16'd10, 16'd20, 16'd30, 16'd40};
    rec_t rec_c = '{32'h5000, 16'd5, 32'h6000, 16'd16, 16'd1, 16'd2, 16'd3, 16'd4};
    rec_t rec_d = '{32'h7000, 16'd7, 32'h8000, 16'd48, 16'd5, 16'd6, 16'd7, 16'd8};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input rec_t r, input int i);
        case (i)
            0:       word_of = r.tbuf;
            1:       word_of = {16'h0000, r.tiles};
            2:       word_of = r.pbuf;
            3:       word_of = {16'h0000, r.stride};
            4:       word_of = {r.xmax, r.xmin};
            default: word_of = {r.ymax, r.ymin};
        endcase
    endfunction

    // Drive a record at the current falling edge and queue the writes/done it should produce.
    task automatic send(input int which, input rec_t r, input int gap, input logic [11:0] base,
                        input logic [5:0] mask, input int extra, input bit hold, output int c);
        exp_t e;
        int   t;
        tbuf = r.tbuf; tiles = r.tiles; pbuf = r.pbuf; stride = r.stride;
        xmin = r.xmin; xmax = r.xmax; ymin = r.ymin; ymax = r.ymax;
        if (which == 0) v0 = 1'b1; else v1 = 1'b1;
        c = cyc;
        t = c + 1 + extra;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                e.cyc = t; e.addr = base + 12'(i); e.data = word_of(r, i);
                if (which == 0) q0.push_back(e); else q1.push_back(e);
                t = t + 1 + gap;
            end
        end
        if (mask != 6'h00) t = t - gap;
        if (which == 0) dq0.push_back(t); else dq1.push_back(t);
        if (!hold) begin
            @(negedge clk);
            v0 = 1'b0; v1 = 1'b0;
        end
    endtask

    task automatic drain(input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (which == 0 && q0.size() == 0 && dq0.size() == 0) break;
            if (which == 1 && q1.size() == 0 && dq1.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard for dut0: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (wv0) begin
            n_assert++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_write: got unexpected addr=%h data=%h at cycle %0d, expected no write", wa0, wd0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (wa0 !== e0.addr || wd0 !== e0.data || cyc !== e0.cyc) begin
                    n_fail++;
                    $display("FAIL dut0_write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                             wa0, wd0, cyc, e0.addr, e0.data, e0.cyc);
                end
            end
        end
        if (d0) begin
            n_assert++;
            if (dq0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_done: got unexpected done at cycle %0d, expected none", cyc);
            end else begin
                de0 = dq0.pop_front();
                if (cyc !== de0) begin
                    n_fail++;
                    $display("FAIL dut0_done: got done at cycle %0d, expected cycle %0d", cyc, de0);
                end
            end
        end
    end

    // Scoreboard for dut1 (GAP_CYCLES=2, base 0xFFE).
    always @(negedge clk) begin
        if (wv1) begin
            n_assert++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_write: got unexpected addr=%h data=%h at cycle %0d, expected no write", wa1, wd1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (wa1 !== e1.addr || wd1 !== e1.data || cyc !== e1.cyc) begin
                    n_fail++;
                    $display("FAIL dut1_write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                             wa1, wd1, cyc, e1.addr, e1.data, e1.cyc);
                end
            end
        end
        if (d1) begin
            n_assert++;
            if (dq1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_done: got unexpected done at cycle %0d, expected none", cyc);
            end else begin
                de1 = dq1.pop_front();
                if (cyc !== de1) begin
                    n_fail++;
                    $display("FAIL dut1_done: got done at cycle %0d, expected cycle %0d", cyc, de1);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({r0, wv0, wa0, wd0, b0, d0} !== {1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut0: got rdy=%b v=%b a=%h d=%h busy=%b done=%b, expected 1 0 000 0 0 0", r0, wv0, wa0, wd0, b0, d0);
        end
        n_assert++;
        if ({r1, wv1, wa1, wd1, b1, d1} !== {1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut1: got rdy=%b v=%b a=%h d=%h busy=%b done=%b, expected 1 0 000 0 0 0", r1, wv1, wa1, wd1, b1, d1);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c;
        n_assert++;
        if (r0 !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b, expected 1", r0); end
        send(0, rec_a, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        repeat (2) @(negedge clk);
        n_assert++;
        if (b0 !== 1'b1 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%b ready=%b, expected busy=1 ready=0", b0, r0);
        end
        drain(0, 30);
        n_assert++;
        if (q0.size() != 0 || dq0.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: got %0d writes and %0d dones pending, expected 0", q0.size(), dq0.size());
        end
    endtask

    task automatic test_gap_wrap();
        int c;
        n_assert++;
        if (r1 !== 1'b1) begin n_fail++; $display("FAIL gap_ready: got %b, expected 1", r1); end
        send(1, rec_a, 2, 12'hFFE, 6'h3F, 0, 1'b0, c);
        repeat (2) @(negedge clk);
        n_assert++;
        if (b1 !== 1'b1 || wv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_idle: got busy=%b valid=%b, expected busy=1 valid=0", b1, wv1);
        end
        drain(1, 40);
        n_assert++;
        if (q1.size() != 0 || dq1.size() != 0) begin
            n_fail++;
            $display("FAIL gap_drain: got %0d writes and %0d dones pending, expected 0", q1.size(), dq1.size());
        end
    endtask

    task automatic test_back_to_back();
        int c, c2;
        send(0, rec_b, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        repeat (5) @(negedge clk);
        send(0, rec_c, 0, 12'h000, 6'h3F, 1, 1'b1, c2);
        @(negedge clk);
        n_assert++;
        if (r0 !== 1'b1 || d0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: got ready=%b done=%b, expected 1 1", r0, d0);
        end
        @(negedge clk);
        v0 = 1'b0;
        n_assert++;
        if (wv0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got valid=%b right after done, expected 1", wv0);
        end
        drain(0, 30);
        n_assert++;
        if (q0.size() != 0 || dq0.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d writes and %0d dones pending, expected 0", q0.size(), dq0.size());
        end
    endtask

    task automatic test_reset_mid();
        int c;
        send(0, rec_d, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        repeat (2) @(negedge clk);
        n_assert++;
        if (wv0 !== 1'b1 || wa0 !== 12'h002) begin
            n_fail++;
            $display("FAIL rmid_idx2: got valid=%b addr=%h, expected 1 002", wv0, wa0);
        end
        reset = 1'b1;
        @(negedge clk);
        n_assert++;
        if (wv0 !== 1'b0 || r0 !== 1'b1 || b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_abort: got valid=%b ready=%b busy=%b, expected 0 1 0", wv0, r0, b0);
        end
        q0.delete();
        dq0.delete();
        reset = 1'b0;
        @(negedge clk);
        send(0, rec_a, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        drain(0, 30);
        n_assert++;
        if (q0.size() != 0 || dq0.size() != 0) begin
            n_fail++;
            $display("FAIL rmid_drain: got %0d writes and %0d dones pending, expected 0", q0.size(), dq0.size());
        end
    endtask

    task automatic test_delta();
        int   c;
        rec_t a2;
        a2 = rec_a;
        a2.stride = 16'd128;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(0, rec_a, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        drain(0, 30);
`ifdef RASTER_DCR_DELTA_EN
        send(0, rec_a, 0, 12'h000, 6'h00, 0, 1'b0, c);
        drain(0, 30);
        send(0, a2, 0, 12'h000, 6'h08, 0, 1'b0, c);
`else
        send(0, rec_a, 0, 12'h000, 6'h3F, 0, 1'b0, c);
        drain(0, 30);
        send(0, a2, 0, 12'h000, 6'h3F, 0, 1'b0, c);
`endif
        drain(0, 30);
        n_assert++;
        if (q0.size() != 0 || dq0.size() != 0) begin
            n_fail++;
            $display("FAIL delta_drain: got %0d writes and %0d dones pending, expected 0", q0.size(), dq0.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        tbuf = '0; tiles = '0; pbuf = '0; stride = '0;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gap_wrap();
        test_back_to_back();
        test_reset_mid();
        test_delta();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
